// File: rtl/pipeline_types.sv
// Shared pipeline types: the rename control payload and the dispatch packet
// handed to the issue queue.
package pipeline_types;

    localparam int DP_PW    = 6;   // physical register index width (64 pregs)
    localparam int DP_TAG_W = 6;   // ROB tag width

    typedef struct packed {
        logic [3:0]  fu_sel;
        logic [7:0]  op;
        logic [19:0] imm;
    } ctrl_payload_t;

    typedef struct packed {
        logic [DP_PW-1:0]    rs1_p;
        logic [DP_PW-1:0]    rs2_p;
        logic [DP_PW-1:0]    rd_p;
        logic                rs1_rdy;
        logic                rs2_rdy;
        logic [DP_TAG_W-1:0] rob_tag;
        ctrl_payload_t       payload;
    } dispatch_pkt_t;

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy table: one bit per preg, set on allocation, cleared
// on writeback. Read ports report readiness including a same-cycle writeback.
module busy_table
    import pipeline_types::*;
#(
    parameter int N_PHYS = 64,
    localparam int PW    = $clog2(N_PHYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en_i,
    input  logic [PW-1:0] set_preg_i,
    input  logic          clr_en_i,
    input  logic [PW-1:0] clr_preg_i,
    input  logic [PW-1:0] rd0_preg_i,
    output logic          rd0_rdy_o,
    input  logic [PW-1:0] rd1_preg_i,
    output logic          rd1_rdy_o
);

    logic [N_PHYS-1:0] busy_d;
    logic [N_PHYS-1:0] busy_q;

    // Next busy state: clear first so a same-cycle set on that preg wins; x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_preg_i] = 1'b0;
        if (set_en_i) busy_d[set_preg_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Readiness with writeback bypass
    always_comb begin
        rd0_rdy_o = (rd0_preg_i == '0) || !busy_q[rd0_preg_i] ||
                    (clr_en_i && (clr_preg_i == rd0_preg_i));
        rd1_rdy_o = (rd1_preg_i == '0) || !busy_q[rd1_preg_i] ||
                    (clr_en_i && (clr_preg_i == rd1_preg_i));
    end

    // Busy bit storage
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: single-entry register between rename and the ROB/issue
// queue. Tags sources with ready bits, tracks wakeups while held, and is
// squashed by misprediction recovery.
module dispatch_stage
    import pipeline_types::*;
#(
    parameter int N_PHYS    = 64,
    parameter int ROB_TAG_W = 6,
    localparam int PW       = $clog2(N_PHYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ren_valid_i,
    output logic                 ren_ready_o,
    input  logic [PW-1:0]        rs1_p_i,
    input  logic [PW-1:0]        rs2_p_i,
    input  logic [PW-1:0]        rd_new_p_i,
    input  logic [PW-1:0]        rd_old_p_i,
    input  logic                 rd_alloc_i,
    input  logic [ROB_TAG_W-1:0] rob_tag_i,
    input  ctrl_payload_t        payload_i,
    output logic                 rob_valid_o,
    input  logic                 rob_ready_i,
    output logic [ROB_TAG_W-1:0] rob_tag_o,
    output logic [PW-1:0]        rob_rd_new_o,
    output logic [PW-1:0]        rob_rd_old_o,
    output logic                 iq_valid_o,
    input  logic                 iq_ready_i,
    output logic [PW-1:0]        iq_rs1_p_o,
    output logic [PW-1:0]        iq_rs2_p_o,
    output logic [PW-1:0]        iq_rd_p_o,
    output logic                 iq_rs1_rdy_o,
    output logic                 iq_rs2_rdy_o,
    output logic [ROB_TAG_W-1:0] iq_rob_tag_o,
    output ctrl_payload_t        iq_payload_o,
    input  logic                 wb_valid_i,
    input  logic [PW-1:0]        wb_preg_i,
    input  logic                 recover_i,
    output logic [31:0]          stall_cnt_o
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic          out_valid_d, out_valid_q;
    dispatch_pkt_t pkt_d, pkt_q;
    logic [PW-1:0] rd_old_d, rd_old_q;
    logic [31:0]   stall_cnt_d, stall_cnt_q;
    logic          fire, capture;
    logic          rs1_rdy, rs2_rdy;

    // Both consumers accept together; a new instruction enters when the slot frees
    always_comb begin
        fire        = out_valid_q && rob_ready_i && iq_ready_i;
        ren_ready_o = (!out_valid_q || fire) && !recover_i;
        capture     = ren_valid_i && ren_ready_o;
    end

    busy_table #(.N_PHYS(N_PHYS)) u_busy (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (capture && rd_alloc_i),
        .set_preg_i (rd_new_p_i),
        .clr_en_i   (wb_valid_i),
        .clr_preg_i (wb_preg_i),
        .rd0_preg_i (rs1_p_i),
        .rd0_rdy_o  (rs1_rdy),
        .rd1_preg_i (rs2_p_i),
        .rd1_rdy_o  (rs2_rdy)
    );

    // Output register: squash, load, drain, or absorb wakeups while held
    always_comb begin
        out_valid_d = out_valid_q;
        pkt_d       = pkt_q;
        rd_old_d    = rd_old_q;
        if (recover_i) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d   = 1'b1;
            pkt_d.rs1_p   = rs1_p_i;
            pkt_d.rs2_p   = rs2_p_i;
            pkt_d.rd_p    = rd_new_p_i;
            pkt_d.rs1_rdy = rs1_rdy;
            pkt_d.rs2_rdy = rs2_rdy;
            pkt_d.rob_tag = rob_tag_i;
            pkt_d.payload = payload_i;
            rd_old_d      = rd_old_p_i;
        end else if (fire) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wb_valid_i) begin
            if (wb_preg_i == pkt_q.rs1_p) pkt_d.rs1_rdy = 1'b1;
            if (wb_preg_i == pkt_q.rs2_p) pkt_d.rs2_rdy = 1'b1;
        end
    end

    // Count cycles an instruction sits at the output without being taken
    always_comb begin
        stall_cnt_d = (out_valid_q && !fire) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            pkt_q       <= '0;
            rd_old_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pkt_q       <= pkt_d;
            rd_old_q    <= rd_old_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs come straight from the register
    always_comb begin
        rob_valid_o  = out_valid_q;
        iq_valid_o   = out_valid_q;
        rob_tag_o    = pkt_q.rob_tag;
        rob_rd_new_o = pkt_q.rd_p;
        rob_rd_old_o = rd_old_q;
        iq_rs1_p_o   = pkt_q.rs1_p;
        iq_rs2_p_o   = pkt_q.rs2_p;
        iq_rd_p_o    = pkt_q.rd_p;
        iq_rs1_rdy_o = pkt_q.rs1_rdy;
        iq_rs2_rdy_o = pkt_q.rs2_rdy;
        iq_rob_tag_o = pkt_q.rob_tag;
        iq_payload_o = pkt_q.payload;
        stall_cnt_o  = stall_cnt_q;
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// Testbench for dispatch_stage: directed scenarios plus random traffic, with
// a per-cycle expected-output scoreboard fed by a reference model.
module tb_dispatch_stage;
    import pipeline_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren_valid_i, ren_ready_o;
    logic [5:0]    rs1_p_i, rs2_p_i, rd_new_p_i, rd_old_p_i;
    logic          rd_alloc_i;
    logic [5:0]    rob_tag_i;
    ctrl_payload_t payload_i;
    logic          rob_valid_o, rob_ready_i;
    logic [5:0]    rob_tag_o, rob_rd_new_o, rob_rd_old_o;
    logic          iq_valid_o, iq_ready_i;
    logic [5:0]    iq_rs1_p_o, iq_rs2_p_o, iq_rd_p_o;
    logic          iq_rs1_rdy_o, iq_rs2_rdy_o;
    logic [5:0]    iq_rob_tag_o;
    ctrl_payload_t iq_payload_o;
    logic          wb_valid_i;
    logic [5:0]    wb_preg_i;
    logic          recover_i;
    logic [31:0]   stall_cnt_o;

    always #5 clk = ~clk;

    dispatch_stage #(.N_PHYS(64), .ROB_TAG_W(6)) dut (
        .clk(clk), .rst(rst),
        .ren_valid_i(ren_valid_i), .ren_ready_o(ren_ready_o),
        .rs1_p_i(rs1_p_i), .rs2_p_i(rs2_p_i),
        .rd_new_p_i(rd_new_p_i), .rd_old_p_i(rd_old_p_i),
        .rd_alloc_i(rd_alloc_i), .rob_tag_i(rob_tag_i), .payload_i(payload_i),
        .rob_valid_o(rob_valid_o), .rob_ready_i(rob_ready_i),
        .rob_tag_o(rob_tag_o), .rob_rd_new_o(rob_rd_new_o), .rob_rd_old_o(rob_rd_old_o),
        .iq_valid_o(iq_valid_o), .iq_ready_i(iq_ready_i),
        .iq_rs1_p_o(iq_rs1_p_o), .iq_rs2_p_o(iq_rs2_p_o), .iq_rd_p_o(iq_rd_p_o),
        .iq_rs1_rdy_o(iq_rs1_rdy_o), .iq_rs2_rdy_o(iq_rs2_rdy_o),
        .iq_rob_tag_o(iq_rob_tag_o), .iq_payload_o(iq_payload_o),
        .wb_valid_i(wb_valid_i), .wb_preg_i(wb_preg_i),
        .recover_i(recover_i), .stall_cnt_o(stall_cnt_o)
    );

    typedef struct {
        bit            v;
        bit            chkf;
        logic [5:0]    rs1, rs2, rd, rdo, tag;
        bit            r1, r2;
        ctrl_payload_t pl;
        logic [31:0]   stall;
    } snap_t;

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t m;
    bit    busy_m [64];
    snap_t mon_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle compare the DUT outputs with the expected snapshot
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_s = exp_q.pop_front();
            chk("rob_valid", rob_valid_o, mon_s.v);
            chk("iq_valid", iq_valid_o, mon_s.v);
            chk("stall_cnt", stall_cnt_o, mon_s.stall);
            if (mon_s.chkf) begin
                chk("rob_tag", rob_tag_o, mon_s.tag);
                chk("rob_rd_new", rob_rd_new_o, mon_s.rd);
                chk("rob_rd_old", rob_rd_old_o, mon_s.rdo);
                chk("iq_rs1_p", iq_rs1_p_o, mon_s.rs1);
                chk("iq_rs2_p", iq_rs2_p_o, mon_s.rs2);
                chk("iq_rd_p", iq_rd_p_o, mon_s.rd);
                chk("iq_rs1_rdy", iq_rs1_rdy_o, mon_s.r1);
                chk("iq_rs2_rdy", iq_rs2_rdy_o, mon_s.r2);
                chk("iq_rob_tag", iq_rob_tag_o, mon_s.tag);
                chk("iq_payload", iq_payload_o, mon_s.pl);
            end
        end
    end

    function automatic bit src_ready(input logic [5:0] p);
        return (p == 6'd0) || !busy_m[p] || (wb_valid_i && wb_preg_i == p);
    endfunction

    // Apply the currently driven inputs for one clock, advance the model and
    // queue the expected post-edge outputs. Returns just after the next negedge.
    task automatic step();
        bit fire, rr, cap;
        snap_t n;
        fire = m.v && rob_ready_i && iq_ready_i;
        rr   = (!m.v || fire) && !recover_i;
        cap  = ren_valid_i && rr;
        #1;
        if (!rst) chk("ren_ready", ren_ready_o, rr);
        n = m;
        if (rst) begin
            n = '{default: '0};
            n.chkf = 1'b1;
            foreach (busy_m[i]) busy_m[i] = 1'b0;
        end else begin
            if (m.v && !fire && n.stall != 32'hFFFF_FFFF) n.stall = n.stall + 1;
            if (recover_i) begin
                n.v = 1'b0;
            end else if (cap) begin
                n.v   = 1'b1;
                n.rs1 = rs1_p_i;  n.rs2 = rs2_p_i;
                n.rd  = rd_new_p_i; n.rdo = rd_old_p_i;
                n.tag = rob_tag_i; n.pl = payload_i;
                n.r1  = src_ready(rs1_p_i);
                n.r2  = src_ready(rs2_p_i);
            end else if (fire) begin
                n.v = 1'b0;
            end else if (m.v && wb_valid_i) begin
                if (wb_preg_i == m.rs1) n.r1 = 1'b1;
                if (wb_preg_i == m.rs2) n.r2 = 1'b1;
            end
            n.chkf = n.v;
            if (wb_valid_i && wb_preg_i != 0) busy_m[wb_preg_i] = 1'b0;
            if (cap && rd_alloc_i && rd_new_p_i != 0) busy_m[rd_new_p_i] = 1'b1;
        end
        m = n;
        exp_q.push_back(m);
        @(negedge clk);
        #1;
    endtask

    task automatic ren(input logic v, input logic [5:0] s1, input logic [5:0] s2,
                       input logic [5:0] rd, input logic al, input logic [5:0] tag);
        ren_valid_i = v; rs1_p_i = s1; rs2_p_i = s2; rd_new_p_i = rd;
        rd_old_p_i = rd ^ 6'h15; rd_alloc_i = al; rob_tag_i = tag;
        payload_i = ctrl_payload_t'($urandom);
    endtask

    function automatic logic [5:0] rp();
        return ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                           : 6'($urandom_range(0, 12));
    endfunction

    logic [5:0]    save_tag;
    ctrl_payload_t save_pl;

    initial begin
        rst = 1'b1; recover_i = 1'b0; wb_valid_i = 1'b0; wb_preg_i = '0;
        rob_ready_i = 1'b1; iq_ready_i = 1'b1;
        ren(1'b0, 0, 0, 0, 1'b0, 0);
        step(); step();
        chk("reset_valid", rob_valid_o, 0);
        chk("reset_stall", stall_cnt_o, 0);
        chk("reset_rs1_p", iq_rs1_p_o, 0);
        chk("reset_payload", iq_payload_o, 0);

        // Independent instruction allocating preg 40
        rst = 1'b0;
        ren(1'b1, 6'd5, 6'd0, 6'd40, 1'b1, 6'd1);
        step();
        chk("t1_valid", iq_valid_o, 1);
        chk("t1_rs1_rdy", iq_rs1_rdy_o, 1);
        chk("t1_rs2_rdy", iq_rs2_rdy_o, 1);
        chk("t1_busy40", dut.u_busy.busy_q[40], 1);

        // Dependent on 40 -> not ready
        ren(1'b1, 6'd40, 6'd3, 6'd41, 1'b1, 6'd2);
        step();
        chk("t2_rs1_rdy", iq_rs1_rdy_o, 0);

        // Held with iq not ready, wakeup for 40
        ren(1'b0, 0, 0, 0, 1'b0, 0);
        iq_ready_i = 1'b0; wb_valid_i = 1'b1; wb_preg_i = 6'd40;
        step();
        chk("t3_rs1_rdy", iq_rs1_rdy_o, 1);
        chk("t3_busy40", dut.u_busy.busy_q[40], 0);

        // Reallocate 40, then a consumer captured in the writeback cycle
        iq_ready_i = 1'b1; wb_valid_i = 1'b0;
        ren(1'b1, 6'd2, 6'd0, 6'd40, 1'b1, 6'd3);
        step();
        ren(1'b1, 6'd40, 6'd0, 6'd42, 1'b1, 6'd4);
        wb_valid_i = 1'b1; wb_preg_i = 6'd40;
        step();
        chk("t5_bypass_rdy", iq_rs1_rdy_o, 1);
        wb_valid_i = 1'b0;

        // Stall for three cycles from a fresh reset
        rst = 1'b1; ren(1'b0, 0, 0, 0, 1'b0, 0);
        step();
        rst = 1'b0;
        ren(1'b1, 6'd1, 6'd2, 6'd20, 1'b1, 6'd9);
        step();
        save_tag = iq_rob_tag_o; save_pl = iq_payload_o;
        rob_ready_i = 1'b1; iq_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ren(1'b1, 6'd3, 6'd4, 6'd21, 1'b1, 6'd10);
            #1 chk("stall_ren_ready", ren_ready_o, 0);
            step();
        end
        chk("stall_cnt3", stall_cnt_o, 3);
        chk("stall_tag_stable", iq_rob_tag_o, 6'd9);
        chk("stall_pl_stable", iq_payload_o, save_pl);

        // Recovery squashes the held instruction, no capture, busy untouched
        recover_i = 1'b1;
        ren(1'b1, 6'd3, 6'd4, 6'd50, 1'b1, 6'd11);
        #1 chk("rec_ren_ready", ren_ready_o, 0);
        step();
        recover_i = 1'b0;
        chk("rec_rob_valid", rob_valid_o, 0);
        chk("rec_iq_valid", iq_valid_o, 0);
        chk("rec_busy50", dut.u_busy.busy_q[50], 0);
        chk("rec_busy20", dut.u_busy.busy_q[20], 1);

        // Set beats clear on the same preg
        iq_ready_i = 1'b1;
        ren(1'b1, 6'd0, 6'd0, 6'd7, 1'b1, 6'd12);
        wb_valid_i = 1'b1; wb_preg_i = 6'd7;
        step();
        chk("setwins_busy7", dut.u_busy.busy_q[7], 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            recover_i   = ($urandom_range(0, 19) == 0);
            rob_ready_i = ($urandom_range(0, 3) != 0);
            iq_ready_i  = ($urandom_range(0, 3) != 0);
            wb_valid_i  = $urandom_range(0, 1);
            wb_preg_i   = rp();
            ren($urandom_range(0, 3) != 0, rp(), rp(), rp(), $urandom_range(0, 3) != 0,
                6'($urandom_range(0, 63)));
            step();
        end

        rst = 1'b0; recover_i = 1'b0; wb_valid_i = 1'b0; ren_valid_i = 1'b0;
        rob_ready_i = 1'b1; iq_ready_i = 1'b1;
        step(); step();
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
